// File: rtl/axi_mem_pkg.sv
// axi_mem_pkg: response codes and channel state encodings shared by the AXI memory slave
package axi_mem_pkg;
  localparam logic [1:0] RESP_OKAY = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_e;
  typedef enum logic {R_IDLE, R_DATA} r_state_e;
endpackage

// File: rtl/axi_mem_slave_ram.sv
// axi_mem_slave_ram: word array with one write port and one registered read port
module axi_mem_slave_ram #(
  parameter int AW = 10,
  parameter int DW = 256
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);
  logic [DW-1:0] mem [2**AW];
  logic [DW-1:0] rdata_q, rdata_d;
  // read samples the array before this cycle's write lands, so a collision returns old data
  always_comb rdata_d = re ? mem[raddr] : rdata_q;
  always_ff @(posedge clk) if (we) mem[waddr] <= wdata;
  always_ff @(posedge clk or negedge rst)
    if (!rst) rdata_q <= '0;
    else rdata_q <= rdata_d;
  assign rdata = rdata_q;
endmodule

// File: rtl/axi_mem_slave.sv
// axi_mem_slave: AXI INCR burst memory slave with independent read/write channels
// Define AXI_MEM_SLAVE_RANGE_CHECK_EN to answer out-of-range bursts with SLVERR.
module axi_mem_slave
  import axi_mem_pkg::*;
#(
  parameter int MEM_AWIDTH = 10,
  parameter int AXI_LEN_WIDTH = 8,
  parameter int AXI_ADDR_WIDTH = 32,
  parameter int AXI_DATA_WIDTH = 256
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      axi_awvalid,
  input  logic [AXI_ADDR_WIDTH-1:0] axi_awaddr,
  input  logic [AXI_LEN_WIDTH-1:0]  axi_awlen,
  output logic                      axi_awready,
  input  logic                      axi_wvalid,
  input  logic [AXI_DATA_WIDTH-1:0] axi_wdata,
  input  logic                      axi_wlast,
  output logic                      axi_wready,
  output logic                      axi_bvalid,
  output logic [1:0]                axi_bresp,
  input  logic                      axi_bready,
  input  logic                      axi_arvalid,
  input  logic [AXI_ADDR_WIDTH-1:0] axi_araddr,
  input  logic [AXI_LEN_WIDTH-1:0]  axi_arlen,
  output logic                      axi_arready,
  output logic                      axi_rvalid,
  output logic [AXI_DATA_WIDTH-1:0] axi_rdata,
  output logic                      axi_rlast,
  output logic [1:0]                axi_rresp,
  input  logic                      axi_rready
);
  localparam int OFF = $clog2(AXI_DATA_WIDTH / 8);
  w_state_e w_state_q, w_state_d;
  r_state_e r_state_q, r_state_d;
  logic [MEM_AWIDTH-1:0] widx_q, widx_d, ridx_q, ridx_d;
  logic [AXI_LEN_WIDTH-1:0] rlen_q, rlen_d, rcnt_q, rcnt_d;
  logic werr_q, werr_d, rerr_q, rerr_d, rlast_q, rlast_d;
  logic [1:0] bresp_q, bresp_d, rresp_q, rresp_d;
  logic aw_err, ar_err, we, re;
  logic [AXI_DATA_WIDTH-1:0] ram_rdata;
`ifdef AXI_MEM_SLAVE_RANGE_CHECK_EN
  assign aw_err = (axi_awaddr >> (OFF + MEM_AWIDTH)) != '0;
  assign ar_err = (axi_araddr >> (OFF + MEM_AWIDTH)) != '0;
`else
  assign aw_err = 1'b0;
  assign ar_err = 1'b0;
`endif
  always_comb begin
    w_state_d = w_state_q;
    widx_d = widx_q;
    werr_d = werr_q;
    bresp_d = bresp_q;
    we = 1'b0;
    axi_awready = rst && w_state_q == W_IDLE;
    axi_wready = w_state_q == W_DATA;
    axi_bvalid = w_state_q == W_RESP;
    if (axi_awready && axi_awvalid) begin
      w_state_d = W_DATA;
      widx_d = MEM_AWIDTH'(axi_awaddr >> OFF);
      werr_d = aw_err;
    end
    if (axi_wready && axi_wvalid) begin
      we = !werr_q;
      widx_d = widx_q + 1'b1;
      if (axi_wlast) begin
        w_state_d = W_RESP;
        bresp_d = werr_q ? RESP_SLVERR : RESP_OKAY;
      end
    end
    if (axi_bvalid && axi_bready) w_state_d = W_IDLE;
  end
  // the RAM address follows ridx_d so the next beat is fetched as the current one is taken
  always_comb begin
    r_state_d = r_state_q;
    ridx_d = ridx_q;
    rlen_d = rlen_q;
    rcnt_d = rcnt_q;
    rlast_d = rlast_q;
    rerr_d = rerr_q;
    rresp_d = rresp_q;
    re = 1'b0;
    axi_arready = rst && r_state_q == R_IDLE;
    axi_rvalid = r_state_q == R_DATA;
    if (axi_arready && axi_arvalid) begin
      r_state_d = R_DATA;
      ridx_d = MEM_AWIDTH'(axi_araddr >> OFF);
      rlen_d = axi_arlen;
      rcnt_d = '0;
      rlast_d = axi_arlen == '0;
      rerr_d = ar_err;
      rresp_d = ar_err ? RESP_SLVERR : RESP_OKAY;
      re = 1'b1;
    end
    if (axi_rvalid && axi_rready) begin
      if (rlast_q) begin
        r_state_d = R_IDLE;
        rlast_d = 1'b0;
      end else begin
        ridx_d = ridx_q + 1'b1;
        rcnt_d = rcnt_q + 1'b1;
        rlast_d = rcnt_d == rlen_q;
        re = 1'b1;
      end
    end
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      w_state_q <= W_IDLE;
      r_state_q <= R_IDLE;
      widx_q <= '0;
      ridx_q <= '0;
      rlen_q <= '0;
      rcnt_q <= '0;
      werr_q <= 1'b0;
      rerr_q <= 1'b0;
      rlast_q <= 1'b0;
      bresp_q <= RESP_OKAY;
      rresp_q <= RESP_OKAY;
    end else begin
      w_state_q <= w_state_d;
      r_state_q <= r_state_d;
      widx_q <= widx_d;
      ridx_q <= ridx_d;
      rlen_q <= rlen_d;
      rcnt_q <= rcnt_d;
      werr_q <= werr_d;
      rerr_q <= rerr_d;
      rlast_q <= rlast_d;
      bresp_q <= bresp_d;
      rresp_q <= rresp_d;
    end
  axi_mem_slave_ram #(.AW(MEM_AWIDTH), .DW(AXI_DATA_WIDTH)) u_ram (
    .clk(clk),
    .rst(rst),
    .we(we),
    .waddr(widx_q),
    .wdata(axi_wdata),
    .re(re),
    .raddr(ridx_d),
    .rdata(ram_rdata)
  );
  assign axi_bresp = bresp_q;
  assign axi_rresp = rresp_q;
  assign axi_rlast = rlast_q;
  assign axi_rdata = rerr_q ? '0 : ram_rdata;
endmodule

// File: doc/axi_mem_slave.md
AXI_MEM_SLAVE -- requirements
Module: axi_mem_slave

Interface
REQ-001 MEM_AWIDTH, default 10: log2 of memory depth in AXI data words.
REQ-002 AXI_LEN_WIDTH, default 8: burst length field width.
REQ-003 AXI_ADDR_WIDTH, default 32: byte address width.
REQ-004 AXI_DATA_WIDTH, default 256: data beat width; power of two, at least 8.
REQ-005 clk  in  1  single clock; all logic on rising edge.
REQ-006 rst  in  1  asynchronous, active-low reset.
REQ-007 axi_awvalid  in  1  write address valid.
REQ-008 axi_awaddr  in  AXI_ADDR_WIDTH  write start byte address.
REQ-009 axi_awlen  in  AXI_LEN_WIDTH  write beats minus one.
REQ-010 axi_awready  out  1  write address accepted.
REQ-011 axi_wvalid  in  1  write data valid.
REQ-012 axi_wdata  in  AXI_DATA_WIDTH  write beat.
REQ-013 axi_wlast  in  1  final write beat.
REQ-014 axi_wready  out  1  write beat accepted.
REQ-015 axi_bvalid  out  1  write response valid.
REQ-016 axi_bresp  out  2  write response code.
REQ-017 axi_bready  in  1  write response accepted.
REQ-018 axi_arvalid  in  1  read address valid.
REQ-019 axi_araddr  in  AXI_ADDR_WIDTH  read start byte address.
REQ-020 axi_arlen  in  AXI_LEN_WIDTH  read beats minus one.
REQ-021 axi_arready  out  1  read address accepted.
REQ-022 axi_rvalid  out  1  read data valid.
REQ-023 axi_rdata  out  AXI_DATA_WIDTH  read beat.
REQ-024 axi_rlast  out  1  final read beat.
REQ-025 axi_rresp  out  2  read response code.
REQ-026 axi_rready  in  1  read beat accepted.

Function
REQ-027 Word index SHALL be byte address shifted right by log2(AXI_DATA_WIDTH/8), truncated to MEM_AWIDTH bits; the index increments by one per beat (INCR) and wraps modulo depth.
REQ-028 The write FSM SHALL have three states: W_IDLE (awready=1), W_DATA (wready=1), W_RESP (bvalid=1).
REQ-029 Write transitions SHALL be: AW handshake moves W_IDLE to W_DATA; a W handshake with wlast moves W_DATA to W_RESP; a B handshake moves W_RESP to W_IDLE.
REQ-030 Each W handshake SHALL write wdata into the array at the current index in that cycle; the burst ends on wlast regardless of awlen.
REQ-031 The read FSM SHALL have two states: R_IDLE (arready=1) and R_DATA (rvalid=1).
REQ-032 After an AR handshake, rvalid SHALL assert on the next cycle; rdata, rlast and rresp SHALL be registered and held stable while rvalid is high and rready is low.
REQ-033 rlast SHALL assert on beat arlen; an R handshake with rlast SHALL return the read FSM to R_IDLE; arlen=0 yields one beat with rlast.
REQ-034 The read and write channels SHALL operate concurrently and independently.
REQ-035 If a read and a write hit the same word in the same cycle, the read SHALL return the pre-write data.
REQ-036 Response codes SHALL be OKAY=2'b00 except as specified in REQ-040.

Reset
REQ-037 When rst is low, both FSMs SHALL go to idle, and awready, wready, bvalid, arvalid-side rvalid and rlast SHALL go to 0, with bresp, rresp and rdata at 0; array contents are not reset.
REQ-038 Reset mid-burst SHALL abandon the burst with no response issued; the first cycle after release SHALL show awready=1 and arready=1.

Configuration
REQ-039 Macro AXI_MEM_SLAVE_RANGE_CHECK_EN SHALL compile the address range check in or out.
REQ-040 With the macro defined, a burst whose start byte address is at or above depth*(AXI_DATA_WIDTH/8) SHALL suppress array writes, return rdata=0, and give bresp/rresp=SLVERR (2'b10); without it, addresses wrap per REQ-027 and always return OKAY.

Structure
REQ-041 Shared package axi_mem_pkg SHALL hold the response codes (OKAY, SLVERR) and the W/R state encodings.
REQ-042 Sub-module axi_mem_slave_ram SHALL hold the array: one write port, one registered read port.

Verification
REQ-043 Write burst: addr 0x40, len 3, data 1..4 -> bvalid one cycle after the wlast beat, bresp=0; read of the same burst returns 1,2,3,4 with rlast on beat 4.
REQ-044 Backpressure: rready toggles 1,0,0,1 -> rdata held stable throughout; no beat lost or duplicated.
REQ-045 Wrap: MEM_AWIDTH=4, read start index 15, len 1 -> beats from index 15 then index 0.
REQ-046 Collision: read index 5 coincides with a write of 0xAA to index 5 -> read returns the old value; the next read returns 0xAA.
REQ-047 Range check: macro defined, write to index = depth -> bresp=2'b10 and array unchanged; macro undefined -> the write lands at index 0 with bresp=0.
REQ-048 Reset mid-burst: rst low during W_DATA beat 2 -> bvalid never asserts; awready=1 in the first cycle after release.
